// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: N valid/ready source channels and one valid/ready sink.
interface rr_arb_mux_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = $clog2(N);

  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux.sv
// N-channel registered multiplexer with run-time selectable round-robin or
// fixed-priority arbitration; one word per cycle throughput.
module rr_arb_mux #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rr_en,
  rr_arb_mux_if.slave  bus
);
  localparam int          SW = $clog2(N);
  localparam int unsigned NU = N;

  logic [SW-1:0] ptr_q, ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_sel_q, out_sel_d;

  logic          any;
  logic          load;
  logic          found;
  int unsigned   idx;
  logic [SW-1:0] gnt;
  logic [W-1:0]  data_sel;
  logic [N-1:0]  in_ready_c;

  assign any  = |bus.in_valid;
  assign load = !out_valid_q || bus.out_ready;

  // Round-robin scans from ptr with wrap; fixed priority scans from index 0.
  always_comb begin
    found = 1'b0;
    idx   = 0;
    gnt   = '0;
    for (int unsigned k = 0; k < NU; k++) begin
      idx = rr_en ? ((k + 32'(ptr_q)) % NU) : k;
      if (!found && bus.in_valid[SW'(idx)]) begin
        gnt   = SW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    data_sel = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (SW'(i) == gnt) data_sel = bus.in_data[i*W +: W];
    end
  end

  always_comb begin
    in_ready_c = '0;
    if (load && any && !rst) in_ready_c[gnt] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (any) begin
        out_valid_d = 1'b1;
        out_data_d  = data_sel;
        out_sel_d   = gnt;
        if (rr_en) ptr_d = (gnt == SW'(N - 1)) ? '0 : gnt + SW'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule
